axis_i2c_top: RTL and testbench



---
 rtl/axis_i2c_top.sv | 242 ++++++++++++++++++++++++
 tb/tb_axis_i2c_top.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_top.sv
// AXI-Stream fed single-master I2C controller: one 24-bit stream word = one
// complete I2C transaction (START, address, optional register byte, one data byte, STOP).
module axis_i2c_top #(
  parameter int MAIN_CLK = 100_000_000,
  parameter int I2C_CLK  = 200_000,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  inout  wire         i2c_sda_io,
  output logic        i2c_scl_o,
  output logic [7:0]  i2c_rdata_o,
  output logic        rvalid_o
);

  localparam int QP = MAIN_CLK / (4 * I2C_CLK);
  localparam int CW = (QP > 1) ? $clog2(QP) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, REG, ACK2, RSTART, ADDR_R,
    ACK3, WDATA, ACK4, RDATA, MNACK, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [23:0]   word_q, word_d;
  logic          nack_q, nack_d;
  logic          rd_ok_q, rd_ok_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          run_q;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          sda_low_dly_q;
  logic [1:0]    sda_sync_q;
  logic          sda_in;
  logic          sample_pt;
  logic          bit_end;

  // Free-running quarter-period divider
  assign tick = (tick_cnt_q == CW'(QP - 1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
    end
  end

  assign sda_in    = sda_sync_q[1];
  assign sample_pt = tick && (phase_q == 2'd2);
  assign bit_end   = tick && (phase_q == 2'd3);

  assign s_axis_tready = run_q && (state_q == IDLE);
  assign i2c_scl_o     = scl_q;
  // SDA drive lags SCL by one clock so data changes after SCL has fallen
  assign i2c_sda_io    = sda_low_dly_q ? 1'b0 : 1'bz;
  assign i2c_rdata_o   = rdata_q;
  assign rvalid_o      = rvalid_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    word_d    = word_q;
    nack_d    = nack_q;
    rd_ok_d   = rd_ok_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    scl_d     = 1'b1;
    sda_low_d = 1'b0;

    if (state_q != IDLE && tick) begin
      phase_d = phase_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && run_q) begin
          word_d    = s_axis_tdata;
          tx_d      = {s_axis_tdata[23:17], BYPASS ? s_axis_tdata[16] : 1'b0};
          bit_cnt_d = 3'd7;
          nack_d    = 1'b0;
          rd_ok_d   = 1'b0;
          phase_d   = 2'd0;
          state_d   = START;
        end
      end

      START: begin
        sda_low_d = (phase_q == 2'd3);
        if (bit_end) begin
          state_d = ADDR;
        end
      end

      RSTART: begin
        scl_d     = phase_q[1];
        sda_low_d = (phase_q == 2'd3);
        if (bit_end) begin
          tx_d    = {word_q[23:17], 1'b1};
          state_d = ADDR_R;
        end
      end

      ADDR, REG, WDATA, ADDR_R: begin
        scl_d     = phase_q[1];
        sda_low_d = ~tx_q[7];
        if (bit_end) begin
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            case (state_q)
              ADDR:    state_d = ACK1;
              REG:     state_d = ACK2;
              ADDR_R:  state_d = ACK3;
              default: state_d = ACK4;
            endcase
          end
        end
      end

      ACK1, ACK2, ACK3, ACK4: begin
        scl_d = phase_q[1];
        if (sample_pt) begin
          nack_d = sda_in;
        end
        if (bit_end) begin
          if (nack_q || state_q == ACK4) begin
            state_d = STOP;
          end else begin
            case (state_q)
              ACK1: begin
                if (!BYPASS) begin
                  tx_d    = word_q[15:8];
                  state_d = REG;
                end else if (word_q[16]) begin
                  state_d = RDATA;
                end else begin
                  tx_d    = word_q[7:0];
                  state_d = WDATA;
                end
              end
              ACK2: begin
                if (word_q[16]) begin
                  state_d = RSTART;
                end else begin
                  tx_d    = word_q[7:0];
                  state_d = WDATA;
                end
              end
              default: state_d = RDATA;
            endcase
          end
        end
      end

      RDATA: begin
        scl_d = phase_q[1];
        if (sample_pt) begin
          rx_d = {rx_q[6:0], sda_in};
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            rd_ok_d = 1'b1;
            state_d = MNACK;
          end
        end
      end

      MNACK: begin
        scl_d = phase_q[1];
        if (bit_end) begin
          state_d = STOP;
        end
      end

      STOP: begin
        scl_d     = phase_q[1];
        sda_low_d = (phase_q != 2'd3);
        if (bit_end) begin
          state_d = IDLE;
          if (rd_ok_q) begin
            rdata_d  = rx_q;
            rvalid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= IDLE;
      phase_q       <= 2'd0;
      bit_cnt_q     <= 3'd7;
      tx_q          <= 8'h00;
      rx_q          <= 8'h00;
      word_q        <= 24'h0;
      nack_q        <= 1'b0;
      rd_ok_q       <= 1'b0;
      rdata_q       <= 8'h00;
      rvalid_q      <= 1'b0;
      run_q         <= 1'b0;
      scl_q         <= 1'b1;
      sda_low_q     <= 1'b0;
      sda_low_dly_q <= 1'b0;
      sda_sync_q    <= 2'b11;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      word_q        <= word_d;
      nack_q        <= nack_d;
      rd_ok_q       <= rd_ok_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      run_q         <= 1'b1;
      scl_q         <= scl_d;
      sda_low_q     <= sda_low_d;
      sda_low_dly_q <= sda_low_q;
      sda_sync_q    <= {sda_sync_q[0], i2c_sda_io};
    end
  end

endmodule

// File: tb/tb_axis_i2c_top.sv
// Directed bench for axis_i2c_top with a behavioural I2C slave that logs bus frames.
module tb_axis_i2c_top;

  localparam int QP      = 100_000_000 / (4 * 5_000_000);
  localparam int EV_S    = 1000;
  localparam int EV_P    = 2000;
  localparam int BUDGET  = 4000;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic [23:0] tdata = 24'h0;
  logic        tvalid = 1'b0;
  logic        tready;
  wire         sda_w;
  logic        scl_w;
  logic [7:0]  rdata;
  logic        rvalid;

  int n_cmp = 0;
  int n_fail = 0;

  axis_i2c_top #(
    .MAIN_CLK(100_000_000),
    .I2C_CLK (5_000_000),
    .BYPASS  (1'b1)
  ) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .i2c_sda_io   (sda_w),
    .i2c_scl_o    (scl_w),
    .i2c_rdata_o  (rdata),
    .rvalid_o     (rvalid)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- slave model / bus logger ----------------
  logic       slave_low = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] rd_byte = 8'hC3;
  logic [7:0] sh = 8'h00;
  logic       reading = 1'b0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  int         bitn = 0;
  int         byte_idx = 0;
  int         log_q[$];
  int         cyc = 0;
  int         last_rise = 0;
  int         scl_period = 0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  always @(posedge clk_i) cyc++;

  always @(scl_w or sda_w) begin
    if (scl_w !== scl_prev) begin
      if (scl_w === 1'b1) begin
        scl_period = cyc - last_rise;
        last_rise  = cyc;
        if (bitn < 8) begin
          sh = {sh[6:0], sda_w};
        end else begin
          log_q.push_back(int'({sda_w, sh}));
          if (byte_idx == 0) reading = sh[0] && (sda_w === 1'b0);
          else if (reading)  reading = (sda_w === 1'b0);
        end
        bitn++;
      end else begin
        if (bitn == 8) begin
          slave_low = reading ? 1'b0 : ack_en;
        end else if (bitn == 9) begin
          bitn = 0;
          byte_idx++;
          slave_low = reading ? ~rd_byte[7] : 1'b0;
        end else if (bitn >= 1) begin
          slave_low = reading ? ~rd_byte[7-bitn] : 1'b0;
        end
      end
    end else if (sda_w !== sda_prev && scl_w === 1'b1) begin
      if (sda_w === 1'b0) begin
        log_q.push_back(EV_S);
        bitn = 0; byte_idx = 0; reading = 1'b0; slave_low = 1'b0;
      end else begin
        log_q.push_back(EV_P);
        bitn = 0; reading = 1'b0; slave_low = 1'b0;
      end
    end
    scl_prev = scl_w;
    sda_prev = sda_w;
  end

  // rvalid monitor
  int         rv_count = 0;
  int         rv_long = 0;
  logic [7:0] rv_data = 8'h00;
  logic       rv_prev = 1'b0;

  always @(negedge clk_i) begin
    if (rvalid === 1'b1) begin
      rv_count++;
      rv_data = rdata;
      if (rv_prev) rv_long++;
    end
    rv_prev = (rvalid === 1'b1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send(input logic [23:0] w, output bit ok);
    int n;
    n = 0;
    @(negedge clk_i);
    tdata  = w;
    tvalid = 1'b1;
    while (tready !== 1'b1 && n < BUDGET) begin
      @(negedge clk_i);
      n++;
    end
    ok = (tready === 1'b1);
    @(negedge clk_i);
    tvalid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk_i);
    while (tready !== 1'b1 && n < BUDGET) begin
      @(negedge clk_i);
      n++;
    end
    ok = (tready === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arstn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    n_cmp++; if (scl_w !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b, expected 1", scl_w); end
    n_cmp++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b, expected 1 (released)", sda_w); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b, expected 0", rvalid); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 00", rdata); end
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_held: got %b, expected 0", tready); end
    arstn_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready_release: got %b, expected 1", tready); end
    $display("test_reset done");
  endtask

  task automatic test_write();
    int base, rv0, got;
    int exp [4];
    bit ok;
    exp = '{EV_S, 'h0A0, 'h05A, EV_P};
    ack_en = 1'b1;
    base = log_q.size();
    rv0  = rv_count;
    send(24'hA0005A, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_accept: got timeout, expected accept"); end
    wait_ready(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_ready_back: got timeout, expected tready=1"); end
    n_cmp++; if (log_q.size() - base != 4) begin n_fail++; $display("FAIL wr_len: got %0d events, expected 4", log_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_cmp++; if (got != exp[i]) begin n_fail++; $display("FAIL wr_ev%0d: got %0h, expected %0h", i, got, exp[i]); end
    end
    n_cmp++; if (scl_period != 4 * QP) begin n_fail++; $display("FAIL wr_scl_period: got %0d, expected %0d", scl_period, 4 * QP); end
    n_cmp++; if (rv_count != rv0) begin n_fail++; $display("FAIL wr_no_rvalid: got %0d pulses, expected 0", rv_count - rv0); end
    $display("test_write done: word a0005a");
  endtask

  task automatic test_read();
    int base, rv0, got;
    int exp [4];
    bit ok;
    exp = '{EV_S, 'h0A1, 'h1C3, EV_P};
    ack_en  = 1'b1;
    rd_byte = 8'hC3;
    base = log_q.size();
    rv0  = rv_count;
    send(24'hA10000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_accept: got timeout, expected accept"); end
    wait_ready(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_ready_back: got timeout, expected tready=1"); end
    @(negedge clk_i);
    n_cmp++; if (log_q.size() - base != 4) begin n_fail++; $display("FAIL rd_len: got %0d events, expected 4", log_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_cmp++; if (got != exp[i]) begin n_fail++; $display("FAIL rd_ev%0d: got %0h, expected %0h", i, got, exp[i]); end
    end
    n_cmp++; if (rv_count != rv0 + 1) begin n_fail++; $display("FAIL rd_rvalid_count: got %0d pulses, expected 1", rv_count - rv0); end
    n_cmp++; if (rv_long != 0) begin n_fail++; $display("FAIL rd_rvalid_width: got %0d long pulses, expected 0", rv_long); end
    n_cmp++; if (rv_data !== 8'hC3) begin n_fail++; $display("FAIL rd_strobe_data: got %h, expected c3", rv_data); end
    n_cmp++; if (rdata !== 8'hC3) begin n_fail++; $display("FAIL rd_rdata_hold: got %h, expected c3", rdata); end
    $display("test_read done: word a10000");
  endtask

  task automatic test_nack();
    int base, rv0, got;
    int exp [3];
    bit ok;
    exp = '{EV_S, 'h1A0, EV_P};
    ack_en = 1'b0;
    base = log_q.size();
    rv0  = rv_count;
    send(24'hA0005A, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL nack_accept: got timeout, expected accept"); end
    wait_ready(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL nack_ready_back: got timeout, expected tready=1"); end
    n_cmp++; if (log_q.size() - base != 3) begin n_fail++; $display("FAIL nack_len: got %0d events, expected 3", log_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_cmp++; if (got != exp[i]) begin n_fail++; $display("FAIL nack_ev%0d: got %0h, expected %0h", i, got, exp[i]); end
    end
    n_cmp++; if (rv_count != rv0) begin n_fail++; $display("FAIL nack_no_rvalid: got %0d pulses, expected 0", rv_count - rv0); end
    n_cmp++; if (rdata !== 8'hC3) begin n_fail++; $display("FAIL nack_rdata_hold: got %h, expected c3", rdata); end
    ack_en = 1'b1;
    $display("test_nack done: word a0005a, slave silent");
  endtask

  task automatic test_back_to_back();
    int base, got, n;
    int exp [8];
    bit ok;
    exp = '{EV_S, 'h0A0, 'h011, EV_P, EV_S, 'h0A0, 'h022, EV_P};
    ack_en = 1'b1;
    base = log_q.size();
    @(negedge clk_i);
    tdata  = 24'hA00011;
    tvalid = 1'b1;
    n = 0;
    while (tready !== 1'b1 && n < BUDGET) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL b2b_tready_drop: got %b, expected 0", tready); end
    tdata = 24'hA00022;
    n = 0;
    while (tready !== 1'b1 && n < BUDGET) begin @(negedge clk_i); n++; end
    n_cmp++; if (log_q.size() - base != 4) begin n_fail++; $display("FAIL b2b_second_wait: got %0d events before 2nd accept, expected 4", log_q.size() - base); end
    @(negedge clk_i);
    tvalid = 1'b0;
    wait_ready(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_ready_back: got timeout, expected tready=1"); end
    n_cmp++; if (log_q.size() - base != 8) begin n_fail++; $display("FAIL b2b_len: got %0d events, expected 8", log_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_cmp++; if (got != exp[i]) begin n_fail++; $display("FAIL b2b_ev%0d: got %0h, expected %0h", i, got, exp[i]); end
    end
    $display("test_back_to_back done: words a00011, a00022");
  endtask

  task automatic test_reset_mid();
    int base, got, n;
    int exp [4];
    bit ok;
    exp = '{EV_S, 'h0A0, 'h033, EV_P};
    ack_en = 1'b1;
    send(24'hA00077, ok);
    n = 0;
    while (!(byte_idx == 1 && bitn == 4) && n < BUDGET) begin @(negedge clk_i); n++; end
    n_cmp++; if (n >= BUDGET) begin n_fail++; $display("FAIL mid_reach_wdata: got timeout, expected WDATA bit 4"); end
    arstn_i = 1'b0;
    #1;
    n_cmp++; if (scl_w !== 1'b1) begin n_fail++; $display("FAIL mid_scl: got %b, expected 1", scl_w); end
    n_cmp++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL mid_sda: got %b, expected 1 (released)", sda_w); end
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL mid_tready: got %b, expected 0", tready); end
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL mid_tready_release: got %b, expected 1", tready); end
    base = log_q.size();
    send(24'hA00033, ok);
    wait_ready(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_next_done: got timeout, expected tready=1"); end
    n_cmp++; if (log_q.size() - base != 4) begin n_fail++; $display("FAIL mid_next_len: got %0d events, expected 4", log_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : -1;
      n_cmp++; if (got != exp[i]) begin n_fail++; $display("FAIL mid_next_ev%0d: got %0h, expected %0h", i, got, exp[i]); end
    end
    $display("test_reset_mid done: word a00077 aborted, a00033 sent");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
